kernel_loader: RTL and testbench

//   Stream-to-bank write sequencer sitting directly upstream of the kernel BRAM array.

---
 rtl/kernel_loader.sv | 120 ++++++++++++
 tb/tb_kernel_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_loader.sv
// Stream-to-bank write sequencer: fills KERNEL_BRAM_NUM banks, each with N words,
// in ascending (bank, addr) order. Each write is registered one cycle after the accept.
module kernel_loader #(
    parameter int KERNEL_BRAM_NUM           = 4,
    parameter int KERNEL_BRAM_ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH                = 32
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic                                 i_start,
    input  logic [KERNEL_BRAM_ADDRESS_WIDTH-1:0] i_words_per_bank,
    input  logic                                 i_valid,
    input  logic [DATA_WIDTH-1:0]                i_data,
    output logic                                 o_ready,
    output logic [KERNEL_BRAM_NUM-1:0]           o_enable,
    output logic [KERNEL_BRAM_NUM-1:0]           o_wenable,
    output logic [KERNEL_BRAM_ADDRESS_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0]                o_bram_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [1:0]                           debug_state
);
    localparam int AW = KERNEL_BRAM_ADDRESS_WIDTH;
    localparam int BW = (KERNEL_BRAM_NUM > 1) ? $clog2(KERNEL_BRAM_NUM) : 1;
    localparam logic [BW-1:0] LAST_BANK = BW'(KERNEL_BRAM_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Stream handshake: a word is accepted on any edge where i_valid && o_ready.
    // o_ready is a registered decode of the LOAD state and never looks at i_valid.
    state_t                      state, state_next;
    logic [BW-1:0]               bank;
    logic [AW-1:0]               addr;
    logic [AW-1:0]               n_words;
    logic                        accept;
    logic                        addr_last;
    logic                        bank_last;
    logic [KERNEL_BRAM_NUM-1:0]  bank_onehot;

    assign accept      = i_valid && o_ready;
    assign addr_last   = (addr == n_words - AW'(1));
    assign bank_last   = (bank == LAST_BANK);
    assign bank_onehot = KERNEL_BRAM_NUM'(1) << bank;
    assign debug_state = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = (i_words_per_bank != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (accept && addr_last && bank_last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decode the next state so they line up with the state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_next;
            o_ready <= (state_next == LOAD);
            o_busy  <= (state_next != IDLE);
            o_done  <= (state_next == DONE);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            bank    <= '0;
            addr    <= '0;
            n_words <= '0;
        end else if (state == IDLE && i_start) begin
            bank    <= '0;
            addr    <= '0;
            n_words <= i_words_per_bank;
        end else if (accept) begin
            if (addr_last) begin
                addr <= '0;
                bank <= bank + BW'(1);
            end else begin
                addr <= addr + AW'(1);
            end
        end
    end

    // Address and data hold their last value between writes; only the enables drop.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_enable    <= '0;
            o_wenable   <= '0;
            o_address   <= '0;
            o_bram_data <= '0;
        end else if (accept) begin
            o_enable    <= bank_onehot;
            o_wenable   <= bank_onehot;
            o_address   <= addr;
            o_bram_data <= i_data;
        end else begin
            o_enable    <= '0;
            o_wenable   <= '0;
        end
    end

endmodule

// File: tb/tb_kernel_loader.sv
// Bench for kernel_loader: randomized streams checked against an arithmetic model
// (word k goes to bank k/N, address k%N), plus a narrow-address instance.
module tb_kernel_loader;
    localparam int NB  = 4;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int AW2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start, valid, ready, busy, done;
    logic [AW-1:0] wpb, addr;
    logic [DW-1:0] data, bdata;
    logic [NB-1:0] en, wen;
    logic [1:0]    dbg;

    logic           start2, valid2, ready2, busy2, done2;
    logic [AW2-1:0] wpb2, addr2;
    logic [DW-1:0]  data2, bdata2;
    logic [NB-1:0]  en2, wen2;
    logic [1:0]     dbg2;

    int total = 0;
    int bad   = 0;

    kernel_loader #(.KERNEL_BRAM_NUM(NB), .KERNEL_BRAM_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_words_per_bank(wpb),
        .i_valid(valid), .i_data(data), .o_ready(ready), .o_enable(en), .o_wenable(wen),
        .o_address(addr), .o_bram_data(bdata), .o_busy(busy), .o_done(done),
        .debug_state(dbg)
    );

    kernel_loader #(.KERNEL_BRAM_NUM(NB), .KERNEL_BRAM_ADDRESS_WIDTH(AW2), .DATA_WIDTH(DW)) dut2 (
        .i_clock(clk), .i_reset(rst), .i_start(start2), .i_words_per_bank(wpb2),
        .i_valid(valid2), .i_data(data2), .o_ready(ready2), .o_enable(en2), .o_wenable(wen2),
        .o_address(addr2), .o_bram_data(bdata2), .o_busy(busy2), .o_done(done2),
        .debug_state(dbg2)
    );

    // Write log: {enable, wenable, address, data} for every cycle with any enable set.
    logic [55:0] got_q[$];
    logic [55:0] exp_q[$];
    logic [39:0] got2_q[$];
    logic [39:0] exp2_q[$];
    int busy_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (en != '0 || wen != '0) got_q.push_back({en, wen, addr, bdata});
        if (en2 != '0) got2_q.push_back({en2, addr2, bdata2});
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; valid = 1'b0; wpb = '0; data = '0;
        #1;
        total++;
        if ({ready, en, wen, addr, bdata, busy, done, dbg} !== '0) begin
            bad++; $display("FAIL reset_idle got=%h exp=0", {ready, en, wen, addr, bdata, busy, done, dbg});
        end
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ready !== 1'b0 || dbg !== 2'd0) begin
            bad++; $display("FAIL reset_release ready=%b state=%0d exp ready=0 state=0", ready, dbg);
        end
        start = 1'b1; wpb = 16'd3;
        @(posedge clk); #1;
        start = 1'b0; valid = 1'b1; data = $urandom;
        @(posedge clk); #1;
        total++;
        if (en !== 4'b0001 || busy !== 1'b1) begin
            bad++; $display("FAIL reset_preload en=%b busy=%b exp en=0001 busy=1", en, busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({ready, en, wen, addr, bdata, busy, done, dbg} !== '0) begin
            bad++; $display("FAIL reset_midload got=%h exp=0", {ready, en, wen, addr, bdata, busy, done, dbg});
        end
        valid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ready !== 1'b0 || dbg !== 2'd0 || en !== '0) begin
            bad++; $display("FAIL reset_after ready=%b state=%0d en=%b exp 0 0 0", ready, dbg, en);
        end
    endtask

    // mode 0: valid always high, 1: valid toggles, 2: random valid.
    // poke: pulse i_start and scramble i_words_per_bank while the load is running.
    task automatic run_load(input int n, input int mode, input bit poke, input string name);
        logic [DW-1:0] words[$];
        logic [NB-1:0] exp_en;
        int tw, k, cyc;
        bit v, r, acc;
        tw = NB * n;
        words.delete(); exp_q.delete(); got_q.delete();
        for (int i = 0; i < tw; i++) words.push_back($urandom);
        for (int i = 0; i < tw; i++) begin
            exp_en = 4'(1 << (i / n));
            exp_q.push_back({exp_en, exp_en, 16'(i % n), words[i]});
        end
        start = 1'b1; wpb = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (ready !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL %s_start ready=%b busy=%b exp 1 1", name, ready, busy);
        end
        k = 0; cyc = 0;
        while (k < tw && cyc < 20 * tw + 20) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            valid = v;
            data  = v ? words[k] : $urandom;
            if (poke) begin
                start = (k == 4 || k == 5);
                wpb   = 16'($urandom_range(0, 65535));
            end
            r   = ready;
            acc = v && r;
            @(posedge clk); #1;
            exp_en = acc ? 4'(1 << (k / n)) : 4'b0;
            if (acc) k++;
            total++;
            if (en !== exp_en || wen !== exp_en) begin
                bad++; $display("FAIL %s_en cyc=%0d en=%b wen=%b exp=%b", name, cyc, en, wen, exp_en);
            end
            total++;
            if ({done, ready} !== {1'(k == tw), 1'(k < tw)}) begin
                bad++; $display("FAIL %s_done cyc=%0d done=%b ready=%b exp done=%b ready=%b",
                                name, cyc, done, ready, k == tw, k < tw);
            end
            cyc++;
        end
        valid = 1'b0; start = 1'b0; wpb = 16'(n);
        total++;
        if (k != tw) begin
            bad++; $display("FAIL %s_timeout accepted=%0d exp=%0d", name, k, tw);
        end
        @(posedge clk); #1;
        total++;
        if ({done, busy, dbg} !== 4'b0) begin
            bad++; $display("FAIL %s_idle done=%b busy=%b state=%0d exp 0 0 0", name, done, busy, dbg);
        end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL %s_write[%0d] got=%h exp=%h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_zero();
        got_q.delete();
        start = 1'b1; wpb = '0;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        total++;
        if ({done, busy, ready, en} !== {1'b1, 1'b1, 1'b0, 4'b0}) begin
            bad++; $display("FAIL zero_pulse done=%b busy=%b ready=%b en=%b exp 1 1 0 0000", done, busy, ready, en);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy_cnt != 1 || done_cnt != 1 || got_q.size() != 0) begin
            bad++; $display("FAIL zero_counts busy=%0d done=%0d writes=%0d exp 1 1 0", busy_cnt, done_cnt, got_q.size());
        end
    endtask

    task automatic test_aw4();
        logic [DW-1:0] words[$];
        int k, cyc, hits;
        bit r;
        words.delete(); exp2_q.delete(); got2_q.delete();
        for (int i = 0; i < NB * 15; i++) words.push_back($urandom);
        for (int i = 0; i < NB * 15; i++) exp2_q.push_back({4'(1 << (i / 15)), 4'(i % 15), words[i]});
        start2 = 1'b1; wpb2 = 4'd15;
        @(posedge clk); #1;
        start2 = 1'b0;
        k = 0; cyc = 0;
        while (k < NB * 15 && cyc < 200) begin
            valid2 = 1'b1; data2 = words[k];
            r = ready2;
            @(posedge clk); #1;
            if (r) k++;
            cyc++;
        end
        valid2 = 1'b0;
        total++;
        if (k != NB * 15 || done2 !== 1'b1) begin
            bad++; $display("FAIL aw4_done accepted=%0d done=%b exp %0d 1", k, done2, NB * 15);
        end
        @(posedge clk); #1;
        hits = 0;
        foreach (got2_q[i]) if (got2_q[i][35:32] == 4'd15) hits++;
        total++;
        if (hits != 0) begin
            bad++; $display("FAIL aw4_addr15 writes=%0d exp=0", hits);
        end
        total++;
        if (got2_q.size() != exp2_q.size()) begin
            bad++; $display("FAIL aw4_count got=%0d exp=%0d", got2_q.size(), exp2_q.size());
        end
        for (int i = 0; i < got2_q.size() && i < exp2_q.size(); i++) begin
            total++;
            if (got2_q[i] !== exp2_q[i]) begin
                bad++; $display("FAIL aw4_write[%0d] got=%h exp=%h", i, got2_q[i], exp2_q[i]);
            end
        end
    endtask

    initial begin
        start2 = 1'b0; valid2 = 1'b0; wpb2 = '0; data2 = '0;
        test_reset();
        run_load(3, 0, 1'b0, "b2b");
        run_load(3, 1, 1'b0, "gap");
        test_zero();
        run_load(3, 2, 1'b1, "poke");
        run_load(5, 2, 1'b0, "reload");
        test_aw4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
